cpu_sequencer: RTL and testbench

Multi-cycle control sequencer for the MIPS datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB over a single shared memory port with a ready handshake. It gates the instruction decoder's combinational write enables into one-cycle strobes and latches its branch decision. It sits between the decoder, the PC/IR registers, the register file and the memory port.

---
 rtl/cpu_sequencer.sv | 126 ++++++++++++
 tb/tb_cpu_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the MIPS datapath.
// Drives a single shared memory port (req held until mem_ready) and gates decoder enables into strobes.
module cpu_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             halt,
  input  logic             dec_mem_wren,
  input  logic             dec_reg_wren,
  input  logic             dec_reg_dmux_sel,
  input  logic [2:0]       dec_pc_control,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_addr_sel,
  output logic             mem_we,
  output logic             ir_we,
  output logic             reg_we,
  output logic             pc_we,
  output logic [2:0]       pc_sel,
  output logic [2:0]       state,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  // Memory handshake: mem_req stays high until the cycle mem_ready is seen; mem_ready is ignored while mem_req is low.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd7
  } state_t;

  localparam int WAIT_W     = $clog2(MEM_TIMEOUT + 2);
  localparam int WAIT_LIMIT = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q;
  logic [2:0]         pc_sel_q;
  logic [CNT_W-1:0]   retired_q;
  logic               instr_end;
  logic               timeout;

  // A wait cycle that would bring the counter to MEM_TIMEOUT faults; a ready in that cycle still completes.
  assign timeout = (MEM_TIMEOUT != 0) && !mem_ready && (wait_q == WAIT_W'(WAIT_LIMIT));

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_addr_sel = 1'b0;
    mem_we       = 1'b0;
    ir_we        = 1'b0;
    reg_we       = 1'b0;
    pc_we        = 1'b0;
    instr_end    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (dec_mem_wren || !dec_reg_dmux_sel) state_d = S_MEM;
        else if (dec_reg_wren)                 state_d = S_WB;
        else                                   instr_end = 1'b1;
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = dec_mem_wren;
        if (mem_ready) begin
          if (dec_mem_wren) instr_end = 1'b1;
          else              state_d   = S_WB;
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        reg_we    = 1'b1;
        instr_end = 1'b1;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
    // Instruction boundary: the only place halt is honoured.
    if (instr_end) begin
      pc_we   = 1'b1;
      state_d = halt ? S_IDLE : S_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      pc_sel_q  <= 3'd0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (mem_req && !mem_ready) wait_q <= wait_q + WAIT_W'(1);
      else                       wait_q <= '0;
      if (state_q == S_EXEC) pc_sel_q <= dec_pc_control;
      if (instr_end) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // In EXEC the branch decision is used before it has been latched.
  assign pc_sel  = (state_q == S_EXEC) ? dec_pc_control : pc_sel_q;
  assign state   = state_q;
  assign fault   = (state_q == S_FAULT);
  assign retired = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized bench for cpu_sequencer: an instruction-level model expands each instruction
// into its expected per-cycle output trace, compared cycle by cycle against the DUT.
module tb_cpu_sequencer;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 2;

  logic             clk, rst_n, run, halt;
  logic             dec_mem_wren, dec_reg_wren, dec_reg_dmux_sel;
  logic [2:0]       dec_pc_control;
  logic             mem_ready;
  logic             mem_req, mem_addr_sel, mem_we, ir_we, reg_we, pc_we;
  logic [2:0]       pc_sel, state;
  logic             fault;
  logic [CNT_W-1:0] retired;

  int n_checks = 0;
  int n_err    = 0;

  // {state[2:0], fault, mem_req, mem_addr_sel, mem_we, ir_we, reg_we, pc_we, pc_sel[2:0], retired[1:0]}
  logic [14:0] exp_q[$];
  logic [2:0]  drv_q[$];   // {run, halt, mem_ready}
  logic [1:0]  ret_exp;
  bit          idle_flag;

  cpu_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .halt(halt),
    .dec_mem_wren(dec_mem_wren), .dec_reg_wren(dec_reg_wren),
    .dec_reg_dmux_sel(dec_reg_dmux_sel), .dec_pc_control(dec_pc_control),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_addr_sel(mem_addr_sel),
    .mem_we(mem_we), .ir_we(ir_we), .reg_we(reg_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .state(state), .fault(fault), .retired(retired)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [14:0] pack(input logic [2:0] st, input logic f, input logic rq,
                                       input logic as, input logic mw, input logic iw,
                                       input logic rw, input logic pw, input logic [2:0] ps,
                                       input logic [1:0] rt);
    return {st, f, rq, as, mw, iw, rw, pw, ps, rt};
  endfunction

  function automatic logic [14:0] observe(input logic mask_pc_sel);
    logic [14:0] o;
    o = {state, fault, mem_req, mem_addr_sel, mem_we, ir_we, reg_we, pc_we, pc_sel, retired};
    if (mask_pc_sel) o[4:2] = 3'b000;
    return o;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [14:0] e, input logic r, input logic h, input logic m);
    exp_q.push_back(e);
    drv_q.push_back({r, h, m});
  endtask

  // ---------------- driver / scoreboard ----------------
  // Called at posedge+1: drive, check at negedge, advance one edge.
  task automatic drain();
    logic [14:0] e;
    logic [2:0]  d;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      d = drv_q.pop_front();
      {run, halt, mem_ready} = d;
      @(negedge clk);
      check($sformatf("cycle_st%0d", e[14:12]), 32'(observe(!e[5])), 32'(e));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check(tag, 32'(observe(1'b0)), 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    ret_exp   = 2'd0;
    idle_flag = 1'b1;
  endtask

  // ---------------- reference model ----------------
  // kind: 0/1 ALU, 2 load, 3 store, 4 jump/branch; fw/mw are wait cycles before mem_ready.
  task automatic gen_instr(input int kind, input int fw, input int mw,
                           input logic hend, input logic [2:0] pcc);
    logic st, ld;
    st = (kind == 3);
    ld = (kind == 2);
    dec_mem_wren     = st;
    dec_reg_wren     = (kind <= 2);
    dec_reg_dmux_sel = ld ? 1'b0 : (st ? rnd() : 1'b1);
    dec_pc_control   = pcc;
    if (idle_flag) begin
      repeat ($urandom_range(0, 2)) push(pack(3'd0, 0,0,0,0,0,0,0, 3'd0, ret_exp), 1'b0, rnd(), rnd());
      push(pack(3'd0, 0,0,0,0,0,0,0, 3'd0, ret_exp), 1'b1, rnd(), rnd());
    end
    repeat (fw) push(pack(3'd1, 0,1,0,0,0,0,0, 3'd0, ret_exp), rnd(), rnd(), 1'b0);
    push(pack(3'd1, 0,1,0,0,1,0,0, 3'd0, ret_exp), rnd(), rnd(), 1'b1);
    push(pack(3'd2, 0,0,0,0,0,0,0, 3'd0, ret_exp), rnd(), rnd(), rnd());
    if (kind == 4) begin
      push(pack(3'd3, 0,0,0,0,0,0,1, pcc, ret_exp), rnd(), hend, rnd());
      ret_exp++;
    end else begin
      push(pack(3'd3, 0,0,0,0,0,0,0, 3'd0, ret_exp), rnd(), rnd(), rnd());
      if (st || ld) begin
        repeat (mw) push(pack(3'd4, 0,1,1,st,0,0,0, 3'd0, ret_exp), rnd(), rnd(), 1'b0);
        if (st) begin
          push(pack(3'd4, 0,1,1,1,0,0,1, pcc, ret_exp), rnd(), hend, 1'b1);
          ret_exp++;
        end else begin
          push(pack(3'd4, 0,1,1,0,0,0,0, 3'd0, ret_exp), rnd(), rnd(), 1'b1);
        end
      end
      if (!st) begin
        push(pack(3'd5, 0,0,0,0,0,1,1, pcc, ret_exp), rnd(), hend, rnd());
        ret_exp++;
      end
    end
    idle_flag = hend;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; run = 1'b0; halt = 1'b0; mem_ready = 1'b0;
    dec_mem_wren = 1'b0; dec_reg_wren = 1'b0; dec_reg_dmux_sel = 1'b1; dec_pc_control = 3'd0;
    ret_exp = 2'd0; idle_flag = 1'b1;
    #1;
    check("reset_async", 32'(observe(1'b0)), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_held", 32'(observe(1'b0)), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed instruction shapes: ADDU, LW with 2 mem waits, SW, BEQ taken, ADDU with halt.
    gen_instr(0, 0, 0, 1'b0, 3'd0); drain();
    gen_instr(2, 0, 2, 1'b0, 3'd0); drain();
    gen_instr(3, 0, 0, 1'b0, 3'd0); drain();
    gen_instr(4, 0, 0, 1'b0, 3'd3); drain();
    gen_instr(0, 0, 0, 1'b1, 3'd0); drain();
    // Longest wait that still completes, in both phases.
    gen_instr(2, MEM_TIMEOUT - 1, MEM_TIMEOUT - 1, 1'b0, 3'd1); drain();

    repeat (60) begin
      gen_instr(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));
      drain();
    end

    // Timeout in FETCH, sticky FAULT that ignores run, then reset clears it.
    do_reset("reset_before_timeout");
    push(pack(3'd0, 0,0,0,0,0,0,0, 3'd0, 2'd0), 1'b1, 1'b0, 1'b0);
    repeat (MEM_TIMEOUT) push(pack(3'd1, 0,1,0,0,0,0,0, 3'd0, 2'd0), 1'b0, 1'b0, 1'b0);
    repeat (3) push(pack(3'd7, 1,0,0,0,0,0,0, 3'd0, 2'd0), 1'b1, rnd(), 1'b1);
    drain();
    do_reset("reset_clears_fault");

    // Reset in the middle of a store's MEM phase.
    gen_instr(3, 0, 1, 1'b0, 3'd5);
    void'(exp_q.pop_back());
    void'(drv_q.pop_back());
    drain();
    mem_ready = 1'b1;
    do_reset("reset_mid_mem");
    push(pack(3'd0, 0,0,0,0,0,0,0, 3'd0, 2'd0), 1'b0, 1'b0, 1'b1);
    push(pack(3'd0, 0,0,0,0,0,0,0, 3'd0, 2'd0), 1'b0, 1'b1, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
